// File: rtl/fir_scheduler_if.sv
// Bundle of the requester, filter-engine and consumer signals around fir_scheduler.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface fir_scheduler_if #(
    parameter int unsigned WIDTH = 24
);
    logic                    ch0_valid;
    logic                    ch1_valid;
    logic signed [WIDTH-1:0] ch0_data;
    logic signed [WIDTH-1:0] ch1_data;
    logic                    ch0_ready;
    logic                    ch1_ready;
    logic                    fir_start;
    logic signed [WIDTH-1:0] fir_sample;
    logic                    fir_done;
    logic signed [WIDTH-1:0] fir_result;
    logic                    out_valid;
    logic                    out_ch;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_ready;
    logic                    timeout_err;

    modport slave (
        input  ch0_valid, ch1_valid, ch0_data, ch1_data,
        input  fir_done, fir_result, out_ready,
        output ch0_ready, ch1_ready, fir_start, fir_sample,
        output out_valid, out_ch, out_data, timeout_err
    );

    modport master (
        output ch0_valid, ch1_valid, ch0_data, ch1_data,
        output fir_done, fir_result, out_ready,
        input  ch0_ready, ch1_ready, fir_start, fir_sample,
        input  out_valid, out_ch, out_data, timeout_err
    );
endinterface

// File: rtl/fir_scheduler.sv
// Two-channel round-robin front end for a single shared FIR engine: one job in flight,
// result held for the consumer, jobs abandoned after TIMEOUT wait cycles.
module fir_scheduler #(
    parameter int unsigned WIDTH   = 24,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    fir_scheduler_if.slave   bus
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StHold  = 2'd3;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    logic [1:0]              state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic [7:0]              wait_cnt_q, wait_cnt_d;
    logic signed [WIDTH-1:0] sample_q, sample_d;
    logic                    ch_q, ch_d;
    logic signed [WIDTH-1:0] result_q, result_d;
    logic                    timeout_err_q, timeout_err_d;

    logic idle;
    logic grant0;
    logic grant1;

    // On a tie the channel that did not win last time gets the grant.
    assign idle   = (state_q == StIdle);
    assign grant0 = idle && bus.ch0_valid && (!bus.ch1_valid || last_grant_q);
    assign grant1 = idle && bus.ch1_valid && (!bus.ch0_valid || !last_grant_q);

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        wait_cnt_d    = wait_cnt_q;
        sample_d      = sample_q;
        ch_d          = ch_q;
        result_d      = result_q;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    sample_d     = grant1 ? bus.ch1_data : bus.ch0_data;
                    ch_d         = grant1;
                    last_grant_d = grant1;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                wait_cnt_d = 8'd0;
                state_d    = StWait;
            end
            StWait: begin
                // A done pulse on the final wait cycle still wins over the timeout.
                if (bus.fir_done) begin
                    result_d = bus.fir_result;
                    state_d  = StHold;
                end else if (wait_cnt_q == TimeoutCnt) begin
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            last_grant_q  <= 1'b1;
            wait_cnt_q    <= 8'd0;
            sample_q      <= '0;
            ch_q          <= 1'b0;
            result_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            wait_cnt_q    <= wait_cnt_d;
            sample_q      <= sample_d;
            ch_q          <= ch_d;
            result_q      <= result_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.ch0_ready   = grant0;
    assign bus.ch1_ready   = grant1;
    assign bus.fir_start   = (state_q == StIssue);
    assign bus.fir_sample  = sample_q;
    assign bus.out_valid   = (state_q == StHold);
    assign bus.out_ch      = ch_q;
    assign bus.out_data    = result_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_fir_scheduler.sv
// Directed bench for fir_scheduler: handshake latency, round-robin order, hold
// back-pressure, timeout edge cases, mid-job reset and stray done pulses.
module tb_fir_scheduler;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    fir_scheduler_if #(.WIDTH(24)) bus ();

    fir_scheduler #(.WIDTH(24), .TIMEOUT(255)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".fir_start"},   24'(bus.fir_start),   24'd0);
        chk({tag, ".fir_sample"},  bus.fir_sample,       24'd0);
        chk({tag, ".out_valid"},   24'(bus.out_valid),   24'd0);
        chk({tag, ".out_ch"},      24'(bus.out_ch),      24'd0);
        chk({tag, ".out_data"},    bus.out_data,         24'd0);
        chk({tag, ".timeout_err"}, 24'(bus.timeout_err), 24'd0);
    endtask

    initial begin
        logic seen_valid;
        n_total = 0;
        n_bad   = 0;
        rst_n          = 1'b0;
        bus.ch0_valid  = 1'b0;
        bus.ch1_valid  = 1'b0;
        bus.ch0_data   = '0;
        bus.ch1_data   = '0;
        bus.fir_done   = 1'b0;
        bus.fir_result = '0;
        bus.out_ready  = 1'b0;
        #1;
        check_reset_outputs("rst");
        chk("rst.ready0", 24'(bus.ch0_ready), 24'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single ch0 job, done 4 cycles after fir_start.
        bus.ch0_valid = 1'b1;
        bus.ch0_data  = 24'sd1000;
        #1;
        chk("t1.ready0", 24'(bus.ch0_ready), 24'd1);
        chk("t1.ready1", 24'(bus.ch1_ready), 24'd0);
        step();
        bus.ch0_valid = 1'b0;
        chk("t1.start",  24'(bus.fir_start), 24'd1);
        chk("t1.sample", bus.fir_sample, 24'd1000);
        step();
        chk("t1.start_off", 24'(bus.fir_start), 24'd0);
        chk("t1.sample_hold", bus.fir_sample, 24'd1000);
        step();
        step();
        step();
        chk("t1.no_valid_yet", 24'(bus.out_valid), 24'd0);
        bus.fir_done   = 1'b1;
        bus.fir_result = 24'sd777;
        step();
        bus.fir_done  = 1'b0;
        bus.out_ready = 1'b1;
        chk("t1.out_valid", 24'(bus.out_valid), 24'd1);
        chk("t1.out_ch",    24'(bus.out_ch),    24'd0);
        chk("t1.out_data",  bus.out_data,       24'd777);
        step();
        bus.out_ready = 1'b0;
        chk("t1.out_gone",  24'(bus.out_valid), 24'd0);

        // Round robin with both channels always valid, from a fresh reset.
        do_reset();
        bus.ch0_valid = 1'b1;
        bus.ch0_data  = 24'sd10;
        bus.ch1_valid = 1'b1;
        bus.ch1_data  = 24'sd20;
        #1;
        for (int i = 0; i < 4; i++) begin
            logic e;
            e = 1'(i % 2);
            chk($sformatf("rr%0d.ready0", i), 24'(bus.ch0_ready), 24'(!e));
            chk($sformatf("rr%0d.ready1", i), 24'(bus.ch1_ready), 24'(e));
            step();
            chk($sformatf("rr%0d.sample", i), bus.fir_sample, e ? 24'd20 : 24'd10);
            chk($sformatf("rr%0d.busy", i), 24'(bus.ch0_ready | bus.ch1_ready), 24'd0);
            step();
            bus.fir_done   = 1'b1;
            bus.fir_result = 24'(100 + i);
            step();
            bus.fir_done = 1'b0;
            chk($sformatf("rr%0d.out_ch", i), 24'(bus.out_ch), 24'(e));
            chk($sformatf("rr%0d.out_data", i), bus.out_data, 24'(100 + i));
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            #1;
        end

        // Back-pressure in HOLD, with a stray done pulse that must be ignored.
        bus.ch1_valid = 1'b0;
        #1;
        chk("bp.ready0", 24'(bus.ch0_ready), 24'd1);
        step();
        step();
        bus.fir_done   = 1'b1;
        bus.fir_result = -24'sd5;
        step();
        bus.fir_done  = 1'b0;
        bus.ch1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.fir_done   = 1'b1;
                bus.fir_result = 24'sd999;
            end else begin
                bus.fir_done = 1'b0;
            end
            #1;
            chk($sformatf("bp%0d.valid", i), 24'(bus.out_valid), 24'd1);
            chk($sformatf("bp%0d.data", i), bus.out_data, -24'sd5);
            chk($sformatf("bp%0d.rdy", i), 24'(bus.ch0_ready | bus.ch1_ready), 24'd0);
            step();
        end
        bus.fir_done  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("bp.accept_valid", 24'(bus.out_valid), 24'd1);
        step();
        bus.out_ready = 1'b0;
        chk("bp.idle_valid", 24'(bus.out_valid), 24'd0);
        chk("bp.idle_ready1", 24'(bus.ch1_ready), 24'd1);
        bus.ch0_valid = 1'b0;
        bus.ch1_valid = 1'b0;

        // Stray done in IDLE.
        bus.fir_done   = 1'b1;
        bus.fir_result = 24'sd123;
        step();
        bus.fir_done = 1'b0;
        chk("idle_done.valid", 24'(bus.out_valid), 24'd0);
        chk("idle_done.start", 24'(bus.fir_start), 24'd0);
        chk("idle_done.data",  bus.out_data, -24'sd5);

        // Done on the very last wait cycle wins over the timeout.
        do_reset();
        bus.ch0_valid = 1'b1;
        bus.ch0_data  = 24'sd55;
        step();
        bus.ch0_valid = 1'b0;
        step();
        for (int i = 0; i < 255; i++) step();
        bus.fir_done   = 1'b1;
        bus.fir_result = 24'sd4242;
        step();
        bus.fir_done = 1'b0;
        chk("edge.valid", 24'(bus.out_valid), 24'd1);
        chk("edge.data",  bus.out_data, 24'd4242);
        chk("edge.err",   24'(bus.timeout_err), 24'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Full timeout with no done.
        bus.ch0_valid = 1'b1;
        bus.ch0_data  = 24'sd66;
        step();
        bus.ch0_valid = 1'b0;
        step();
        seen_valid = 1'b0;
        for (int i = 0; i < 255; i++) begin
            step();
            seen_valid = seen_valid | bus.out_valid;
        end
        chk("to.err_before", 24'(bus.timeout_err), 24'd0);
        step();
        chk("to.err_after",  24'(bus.timeout_err), 24'd1);
        chk("to.never_valid", 24'(seen_valid | bus.out_valid), 24'd0);
        bus.ch1_valid = 1'b1;
        bus.ch1_data  = 24'sd77;
        #1;
        chk("to.next_ready1", 24'(bus.ch1_ready), 24'd1);
        step();
        bus.ch1_valid = 1'b0;
        chk("to.next_sample", bus.fir_sample, 24'd77);
        step();
        step();
        step();
        chk("to.err_sticky", 24'(bus.timeout_err), 24'd1);

        // Reset in WAIT, then a stray done.
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        rst_n = 1'b1;
        step();
        bus.fir_done   = 1'b1;
        bus.fir_result = 24'sd31;
        step();
        bus.fir_done = 1'b0;
        step();
        chk("mid.no_valid", 24'(bus.out_valid), 24'd0);
        chk("mid.out_data", bus.out_data, 24'd0);
        chk("mid.err",      24'(bus.timeout_err), 24'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
